// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: byte-in / event-out bundle between a PS/2 receiver, the decoder and its consumer.
interface ps2_scancode_decoder_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [7:0]    iCODE;
    logic          iCODE_VALID;
    logic [7:0]    oEVT_CODE;
    logic          oEVT_EXT;
    logic          oEVT_REL;
    logic          oEVT_VALID;
    logic          iEVT_READY;
    logic [CW-1:0] oCOUNT;
    logic          oOVF;
    logic          oERR;
    modport slave (
        input  iCODE, iCODE_VALID, iEVT_READY,
        output oEVT_CODE, oEVT_EXT, oEVT_REL, oEVT_VALID, oCOUNT, oOVF, oERR
    );
    modport master (
        output iCODE, iCODE_VALID, iEVT_READY,
        input  oEVT_CODE, oEVT_EXT, oEVT_REL, oEVT_VALID, oCOUNT, oOVF, oERR
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns raw PS/2 set-2 bytes into make/release events
// (E0/F0 prefixes, optional typematic filtering) queued in a FWFT FIFO.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH    = 4,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input logic                  iCLK_50,
    input logic                  iRST,
    ps2_scancode_decoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic          held_vld_q, held_vld_d;
    logic          held_ext_q, held_ext_d;
    logic [7:0]    held_code_q, held_code_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          special, prefix, evt, evt_ext, evt_rel;
    logic          match, push, pop, full, wr_en;
    logic [9:0]    head;

    always_comb begin
        special = bus.iCODE inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        prefix  = bus.iCODE == 8'hE0 || bus.iCODE == 8'hF0;
        state_d = state_q;
        err_d   = 1'b0;
        evt     = 1'b0;
        evt_ext = 1'b0;
        evt_rel = 1'b0;
        if (bus.iCODE_VALID) begin
            if (special) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = bus.iCODE == 8'hE0 ? EXT : bus.iCODE == 8'hF0 ? BRK : IDLE;
                        evt     = !prefix;
                    end
                    EXT: begin
                        state_d = bus.iCODE == 8'hF0 ? EXT_BRK : bus.iCODE == 8'hE0 ? EXT : IDLE;
                        evt     = !prefix;
                        evt_ext = 1'b1;
                    end
                    BRK: begin
                        state_d = IDLE;
                        err_d   = prefix;
                        evt     = !prefix;
                        evt_rel = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        err_d   = prefix;
                        evt     = !prefix;
                        evt_ext = 1'b1;
                        evt_rel = 1'b1;
                    end
                endcase
            end
        end
    end

    // Held key tracks the last emitted make so typematic repeats can be dropped.
    always_comb begin
        match       = held_vld_q && held_ext_q == evt_ext && held_code_q == bus.iCODE;
        push        = evt && !(FILTER_REPEAT && !evt_rel && match);
        held_vld_d  = held_vld_q;
        held_ext_d  = held_ext_q;
        held_code_d = held_code_q;
        if (push && !evt_rel) begin
            held_vld_d  = 1'b1;
            held_ext_d  = evt_ext;
            held_code_d = bus.iCODE;
        end else if (evt && evt_rel && match) begin
            held_vld_d  = 1'b0;
        end
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        full  = cnt_q == CW'(FIFO_DEPTH);
        pop   = cnt_q != '0 && bus.iEVT_READY;
        wr_en = push && (!full || pop);
        wr_d  = wr_q + AW'(wr_en);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
        ovf_d = ovf_q | (push && full && !pop);
    end

    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            held_vld_q  <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= 8'h00;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            held_vld_q  <= held_vld_d;
            held_ext_q  <= held_ext_d;
            held_code_q <= held_code_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge iCLK_50) begin
        if (wr_en) mem_q[wr_q] <= {evt_ext, evt_rel, bus.iCODE};
    end

    assign head           = mem_q[rd_q];
    assign bus.oEVT_VALID = cnt_q != '0;
    assign bus.oEVT_CODE  = bus.oEVT_VALID ? head[7:0] : 8'h00;
    assign bus.oEVT_REL   = bus.oEVT_VALID & head[8];
    assign bus.oEVT_EXT   = bus.oEVT_VALID & head[9];
    assign bus.oCOUNT     = cnt_q;
    assign bus.oOVF       = ovf_q;
    assign bus.oERR       = err_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: scoreboard bench; expected events are queued as bytes are sent
// and compared whenever the decoder hands an event to the consumer.
module tb_ps2_scancode_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_scancode_decoder_if #(.FIFO_DEPTH(4)) bus ();
    ps2_scancode_decoder #(.FIFO_DEPTH(4), .FILTER_REPEAT(1'b1)) dut (
        .iCLK_50(clk),
        .iRST   (rst),
        .bus    (bus)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_pop = 0;
    int         n_err = 0;
    int         p0, e0;
    logic [9:0] sb[$];
    logic [9:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.oERR === 1'b1) n_err++;
        if (bus.oEVT_VALID === 1'b1 && bus.iEVT_READY) begin
            mon_exp = sb.size() != 0 ? sb.pop_front() : 10'h3FF;
            check("evt", {bus.oEVT_EXT, bus.oEVT_REL, bus.oEVT_CODE}, mon_exp);
            n_pop++;
        end
    end

    task automatic ev(input logic [7:0] code, input logic ext, input logic rel);
        sb.push_back({ext, rel, code});
    endtask

    task automatic send(input logic [7:0] b);
        bus.iCODE       = b;
        bus.iCODE_VALID = 1'b1;
        @(posedge clk);
        #1 bus.iCODE_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && (sb.size() != 0 || bus.oEVT_VALID); i++) idle(1);
        check(tag, sb.size(), 0);
    endtask

    initial begin
        bus.iCODE       = 8'h00;
        bus.iCODE_VALID = 1'b0;
        bus.iEVT_READY  = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_code", bus.oEVT_CODE, 8'h00);
        check("rst_ext", bus.oEVT_EXT, 0);
        check("rst_rel", bus.oEVT_REL, 0);
        check("rst_valid", bus.oEVT_VALID, 0);
        check("rst_count", bus.oCOUNT, 0);
        check("rst_ovf", bus.oOVF, 0);
        check("rst_err", bus.oERR, 0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // basic make / release with single-cycle latency
        bus.iEVT_READY = 1'b1;
        check("lat_pre", bus.oEVT_VALID, 0);
        ev(8'h1C, 0, 0);
        send(8'h1C);
        check("lat_make", bus.oEVT_VALID, 1);
        idle(3);
        ev(8'h1C, 0, 1);
        send(8'hF0);
        check("prefix_noevt", bus.oEVT_VALID, 0);
        send(8'h1C);
        check("lat_rel", bus.oEVT_VALID, 1);
        idle(3);

        // extended make / release
        ev(8'h75, 1, 0);
        send(8'hE0); send(8'h75);
        ev(8'h75, 1, 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(4);
        check("ext_no_err", n_err, 0);

        // typematic filtering
        p0 = n_pop;
        ev(8'h1C, 0, 0); ev(8'h1C, 0, 1); ev(8'h1C, 0, 0);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        idle(4);
        check("repeat_events", n_pop - p0, 3);

        // overflow with consumer stalled
        bus.iEVT_READY = 1'b0;
        ev(8'h15, 0, 0); ev(8'h1D, 0, 0); ev(8'h24, 0, 0); ev(8'h2D, 0, 0);
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        check("ovf_count", bus.oCOUNT, 4);
        check("ovf_flag", bus.oOVF, 1);
        idle(2);
        check("ovf_hold_count", bus.oCOUNT, 4);
        bus.iEVT_READY = 1'b1;
        drain("ovf_drain", 20);
        check("ovf_empty", bus.oCOUNT, 0);
        check("ovf_sticky", bus.oOVF, 1);

        // prefix protocol error and special byte discard
        ev(8'h1C, 0, 1);
        send(8'hF0); send(8'h1C);
        idle(2);
        e0 = n_err;
        ev(8'h29, 0, 0);
        send(8'hF0); send(8'hE0);
        check("err_high", bus.oERR, 1);
        send(8'h29);
        check("err_low", bus.oERR, 0);
        idle(2);
        check("err_pulses", n_err - e0, 1);
        ev(8'h1C, 0, 0);
        send(8'hE0); send(8'hAA); send(8'h1C);
        drain("special_drain", 10);
        check("special_no_err", n_err - e0, 1);

        // simultaneous push and pop while full, across pointer wrap
        bus.iEVT_READY = 1'b0;
        ev(8'h16, 0, 0); ev(8'h1E, 0, 0); ev(8'h26, 0, 0); ev(8'h25, 0, 0); ev(8'h2E, 0, 0);
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        check("pp_full", bus.oCOUNT, 4);
        bus.iEVT_READY = 1'b1;
        send(8'h2E);
        check("pp_count", bus.oCOUNT, 4);
        drain("pp_drain", 20);

        // reset mid-prefix with events queued
        bus.iEVT_READY = 1'b0;
        send(8'h3C); send(8'h4B); send(8'hE0);
        check("pre_rst_count", bus.oCOUNT, 2);
        rst = 1'b1;
        #2;
        check("mid_rst_count", bus.oCOUNT, 0);
        check("mid_rst_valid", bus.oEVT_VALID, 0);
        check("mid_rst_ovf", bus.oOVF, 0);
        idle(1);
        rst = 1'b0;
        bus.iEVT_READY = 1'b1;
        ev(8'h74, 0, 0);
        send(8'h74);
        check("post_rst_valid", bus.oEVT_VALID, 1);
        drain("post_rst_drain", 10);
        check("empty_ready_count", bus.oCOUNT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
